// File: rtl/sync_fifo_fwft.sv
// Synchronous FIFO of any depth >= 2, with occupancy count, programmable
// almost flags, one-cycle overflow/underflow pulses and an optional FWFT read port.
module sync_fifo_fwft #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 32,
    parameter int FWFT          = 0,
    parameter int AF_THRESH     = DEPTH - 1,
    parameter int AE_THRESH     = 1,
    parameter int POINTER_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   almost_full,
    output logic                   overflow,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   almost_empty,
    output logic                   underflow,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [WIDTH-1:0]         mem [DEPTH];
    logic [POINTER_WIDTH-1:0] wr_ptr;
    logic [POINTER_WIDTH-1:0] rd_ptr;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic                     wr_acc;
    logic                     rd_acc;

    // Handshake: a write is taken when wr_en && !full, a read when rd_en && !empty;
    // a refused request touches no state except the overflow/underflow pulse next cycle.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    assign count        = count_q;
    assign full         = (count_q == COUNT_WIDTH'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= COUNT_WIDTH'(AF_THRESH));
    assign almost_empty = (count_q <= COUNT_WIDTH'(AE_THRESH));

    // Depth need not be a power of two, so wrap with an explicit compare.
    function automatic logic [POINTER_WIDTH-1:0] next_ptr(input logic [POINTER_WIDTH-1:0] p);
        if (p == POINTER_WIDTH'(DEPTH - 1)) begin
            return '0;
        end
        return p + POINTER_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
                2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = mem[rd_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: a standard-read and an FWFT instance share stimulus
// and are compared against a queue-based reference model.
module tb_sync_fifo_fwft;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int CW    = 3;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;

    logic             full, almost_full, overflow, empty, almost_empty, underflow;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             f_full, f_almost_full, f_overflow, f_empty, f_almost_empty, f_underflow;
    logic [WIDTH-1:0] f_dout;
    logic [CW-1:0]    f_count;

    int checks;
    int failures;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ovf;
    logic             exp_unf;

    sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
        .overflow(overflow), .rd_en(rd_en), .dout(dout), .empty(empty),
        .almost_empty(almost_empty), .underflow(underflow), .count(count)
    );

    sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(f_full), .almost_full(f_almost_full),
        .overflow(f_overflow), .rd_en(rd_en), .dout(f_dout), .empty(f_empty),
        .almost_empty(f_almost_empty), .underflow(f_underflow), .count(f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; the model applies the FIFO rules at the edge.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
        bit was_full;
        bit was_empty;
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        exp_ovf   = w && was_full;
        exp_unf   = r && was_empty;
        if (r && !was_empty) exp_dout = exp_q.pop_front();
        if (w && !was_full) exp_q.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b/%b exp=1/1", empty, almost_empty); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b/%b exp=0/0", full, almost_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b/%b exp=0/0", overflow, underflow); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 8'(i * 8'h11), 1'b0);
            checks++; if (count !== 3'(i)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
            checks++; if (almost_full !== (i >= 4)) begin failures++; $display("FAIL fill_af got=%b exp=%b", almost_full, (i >= 4)); end
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
        cycle(1'b1, 8'h66, 1'b0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        checks++; if (count !== 3'd5) begin failures++; $display("FAIL ovf_count got=%0d exp=5", count); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (dout !== 8'(i * 8'h11)) begin failures++; $display("FAIL drain_dout got=%h exp=%h", dout, 8'(i * 8'h11)); end
            checks++; if (f_count !== 3'(5 - i)) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", f_count, 5 - i); end
        end
        checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b/%b exp=1/1", empty, almost_empty); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_pulse got=%b exp=1", underflow); end
        checks++; if (dout !== 8'h55) begin failures++; $display("FAIL unf_hold got=%h exp=55", dout); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 8'h9c, 1'b1);
        checks++; if (count !== 3'd1 || underflow !== 1'b1) begin failures++; $display("FAIL sim_empty count=%0d unf=%b exp=1/1", count, underflow); end
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL sim_prefull got=%b exp=1", full); end
        cycle(1'b1, 8'he7, 1'b1);
        checks++; if (count !== 3'd4 || overflow !== 1'b1) begin failures++; $display("FAIL sim_full count=%0d ovf=%b exp=4/1", count, overflow); end
        checks++; if (dout !== 8'h9c) begin failures++; $display("FAIL sim_full_dout got=%h exp=9c", dout); end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h77, 1'b1);
        checks++; if (count !== 3'd2 || overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL sim_mid count=%0d ovf=%b unf=%b exp=2/0/0", count, overflow, underflow); end
        checks++; if (dout !== exp_dout) begin failures++; $display("FAIL sim_mid_dout got=%h exp=%h", dout, exp_dout); end
        while (exp_q.size() > 0) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (dout !== exp_dout) begin failures++; $display("FAIL sim_order got=%h exp=%h", dout, exp_dout); end
        end
        checks++; if (exp_dout !== 8'h77 || empty !== 1'b1) begin failures++; $display("FAIL sim_last got=%h/%b exp=77/1", exp_dout, empty); end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 13; i++) begin
            logic w, r;
            int n;
            n = exp_q.size();
            if (n <= 1)      begin w = 1'b1; r = 1'($urandom_range(0, 1)); end
            else if (n >= 3) begin w = 1'($urandom_range(0, 1)); r = 1'b1; end
            else             begin w = 1'($urandom_range(0, 1)); r = !w || 1'($urandom_range(0, 1)); end
            cycle(w, 8'($urandom_range(0, 255)), r);
            checks++; if (dout !== exp_dout) begin failures++; $display("FAIL wrap_dout got=%h exp=%h", dout, exp_dout); end
            checks++; if (count !== 3'(exp_q.size()) || count < 3'd1 || count > 3'd3) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", count, exp_q.size()); end
        end
        while (exp_q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_fwft();
        cycle(1'b1, 8'ha5, 1'b0);
        checks++; if (f_empty !== 1'b0 || f_dout !== 8'ha5) begin failures++; $display("FAIL fwft_first empty=%b dout=%h exp=0/a5", f_empty, f_dout); end
        cycle(1'b1, 8'h5a, 1'b0);
        checks++; if (f_dout !== 8'ha5) begin failures++; $display("FAIL fwft_head got=%h exp=a5", f_dout); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (f_dout !== 8'h5a) begin failures++; $display("FAIL fwft_pop got=%h exp=5a", f_dout); end
        checks++; if (dout !== 8'ha5) begin failures++; $display("FAIL std_pop got=%h exp=a5", dout); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (f_empty !== 1'b1) begin failures++; $display("FAIL fwft_empty got=%b exp=1", f_empty); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            checks++;
            if (count !== 3'(exp_q.size()) || f_count !== 3'(exp_q.size())) begin
                failures++; $display("FAIL rand_count got=%0d/%0d exp=%0d", count, f_count, exp_q.size());
            end
            checks++;
            if (full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0) ||
                almost_full !== (exp_q.size() >= 4) || almost_empty !== (exp_q.size() <= 1)) begin
                failures++; $display("FAIL rand_flags got=f%b e%b af%b ae%b size=%0d", full, empty, almost_full, almost_empty, exp_q.size());
            end
            checks++;
            if (overflow !== exp_ovf || underflow !== exp_unf || f_overflow !== exp_ovf || f_underflow !== exp_unf) begin
                failures++; $display("FAIL rand_err got=%b%b/%b%b exp=%b%b", overflow, underflow, f_overflow, f_underflow, exp_ovf, exp_unf);
            end
            checks++; if (dout !== exp_dout) begin failures++; $display("FAIL rand_dout got=%h exp=%h", dout, exp_dout); end
            if (exp_q.size() > 0) begin
                checks++; if (f_dout !== exp_q[0]) begin failures++; $display("FAIL rand_fwft_dout got=%h exp=%h", f_dout, exp_q[0]); end
            end
        end
    endtask

    task automatic test_async_reset();
        while (exp_q.size() > 0) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL arst_pre got=%0d exp=3", count); end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || f_count !== 3'd0) begin failures++; $display("FAIL arst_count got=%0d/%0d exp=0", count, f_count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL arst_flags empty=%b full=%b exp=1/0", empty, full); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL arst_dout got=%h exp=00", dout); end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'hc3, 1'b0);
        checks++; if (f_dout !== 8'hc3 || count !== 3'd1) begin failures++; $display("FAIL arst_new_fwft dout=%h count=%0d exp=c3/1", f_dout, count); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (dout !== 8'hc3 || empty !== 1'b1) begin failures++; $display("FAIL arst_new_read dout=%h empty=%b exp=c3/1", dout, empty); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_fwft();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
